// File: rtl/stream_program_loader.sv
// Byte-stream program loader: 16-bit big-endian word count, MSB-first word assembly,
// one-cycle memory write strobes. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module stream_program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  busy,
  output logic                  load_complete,
  output logic                  load_error,
  output logic [1:0]            error_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam int BPW  = DATA_WIDTH / 8;
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [16:0]     DEPTH    = 17'(2 ** ADDR_WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK  = 3'd5,
`endif
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHECK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t                r_state, w_next;
  logic                  r_in_ready;
  logic [15:0]           r_count;
  logic [IDXW-1:0]       r_byte_idx;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_write_data;
  logic                  r_mem_write;
  logic                  r_load_complete;
  logic                  r_load_error;
  logic [1:0]            r_error_code;
  logic [ADDR_WIDTH:0]   r_words_loaded;

  logic                  w_xfer;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_rx_next;
  logic [16:0]           w_hdr_count;
  logic [ADDR_WIDTH:0]   w_wl_inc;
  logic [DATA_WIDTH-1:0] w_word_next;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_last_byte = (r_byte_idx == LAST_IDX);
  assign w_hdr_count = {1'b0, r_count[15:8], in_data};
  assign w_wl_inc    = r_words_loaded + (ADDR_WIDTH+1)'(1);
  assign w_last_word = (17'(w_wl_inc) == {1'b0, r_count});

  // Only the leading BPW-1 bytes need storage; the final byte comes straight from in_data.
  generate
    if (BPW > 1) begin : g_part
      logic [DATA_WIDTH-9:0] r_part;
      assign w_word_next = {r_part, in_data};
      always_ff @(posedge clock or posedge reset) begin
        if (reset)                          r_part <= '0;
        else if (r_state == S_DATA && w_xfer) r_part <= w_word_next[DATA_WIDTH-9:0];
      end
    end else begin : g_byte
      assign w_word_next = in_data;
    end
  endgenerate

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_ck_expect;
  assign w_ck_expect = ~r_sum + 8'd1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start_load) w_next = S_HDR_HI;
      S_HDR_HI: if (w_xfer) w_next = S_HDR_LO;
      S_HDR_LO: if (w_xfer) begin
        if (w_hdr_count > DEPTH)       w_next = S_ERROR;
        else if (w_hdr_count == 17'd0) w_next = S_FINAL;
        else                           w_next = S_DATA;
      end
      S_DATA:  if (w_xfer && w_last_byte) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_FINAL : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (w_xfer) w_next = (in_data == w_ck_expect) ? S_DONE : S_ERROR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_next = (w_next == S_HDR_HI) || (w_next == S_HDR_LO) || (w_next == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    if (w_next == S_CHECK) w_rx_next = 1'b1;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_ready       <= 1'b0;
      r_count          <= '0;
      r_byte_idx       <= '0;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
      r_mem_write      <= 1'b0;
      r_load_complete  <= 1'b0;
      r_load_error     <= 1'b0;
      r_error_code     <= 2'b00;
      r_words_loaded   <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum            <= '0;
`endif
    end else begin
      // in_ready is registered from the next state so it never depends on in_valid
      r_in_ready <= w_rx_next;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: if (start_load) begin
          r_load_complete <= 1'b0;
          r_load_error    <= 1'b0;
          r_error_code    <= 2'b00;
          r_words_loaded  <= '0;
          r_mem_addr      <= '0;
`ifdef LOADER_CHECKSUM_EN
          r_sum           <= '0;
`endif
        end
        S_HDR_HI: if (w_xfer) r_count[15:8] <= in_data;
        S_HDR_LO: if (w_xfer) begin
          r_count[7:0] <= in_data;
          r_byte_idx   <= '0;
          if (w_hdr_count > DEPTH) begin
            r_error_code <= 2'b01;
            r_load_error <= 1'b1;
          end
        end
        S_DATA: if (w_xfer) begin
`ifdef LOADER_CHECKSUM_EN
          r_sum <= r_sum + in_data;
`endif
          if (w_last_byte) begin
            r_mem_write_data <= w_word_next;
            r_mem_write      <= 1'b1;
            r_byte_idx       <= '0;
          end else begin
            r_byte_idx <= r_byte_idx + IDXW'(1);
          end
        end
        S_WRITE: begin
          r_mem_write    <= 1'b0;
          r_words_loaded <= w_wl_inc;
          if (!w_last_word) r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: if (w_xfer && in_data != w_ck_expect) begin
          r_error_code <= 2'b10;
          r_load_error <= 1'b1;
        end
`endif
        default: ;
      endcase
      if (w_next == S_DONE && r_state != S_DONE) r_load_complete <= 1'b1;
    end
  end

  assign in_ready       = r_in_ready;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_write_data;
  assign mem_write      = r_mem_write;
  assign busy           = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign load_complete  = r_load_complete;
  assign load_error     = r_load_error;
  assign error_code     = r_error_code;
  assign words_loaded   = r_words_loaded;
endmodule

// File: doc/stream_program_loader.md
Name: stream_program_loader

Overview:
- Synthesizable successor to the file-based program loader. It receives a program image as a byte stream over a valid/ready handshake from a host link such as a UART receiver or debug bridge.
- It assembles the bytes into DATA_WIDTH words and writes them to instruction memory at addresses 0..N-1, where N comes from a stream header.
- It reports completion or error, and can be re-armed without a reset.

Parameters:
- DATA_WIDTH, 16, instruction word width; must be a multiple of 8 and at least 8.
- ADDR_WIDTH, 5, memory address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start_load  input  1  start request, sampled in IDLE/DONE/ERROR
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_addr  output  ADDR_WIDTH  write address
- mem_write_data  output  DATA_WIDTH  write data
- mem_write  output  1  one-cycle write strobe
- busy  output  1  high in any state other than IDLE/DONE/ERROR
- load_complete  output  1  sticky; image loaded successfully
- load_error  output  1  sticky; load aborted
- error_code  output  2  00 none, 01 count > DEPTH, 10 checksum mismatch
- words_loaded  output  ADDR_WIDTH+1  number of words written in the current load

Behaviour:
- Reset: clock is clock; reset is reset, asynchronous, active-high. All outputs go to 0 and the state goes to IDLE.
- Byte transfer: a byte transfers on a rising edge where in_valid && in_ready. in_ready is high only in HDR_HI, HDR_LO, DATA and CHECK. in_ready is a registered function of state and never depends on in_valid.
- Stream format: 16-bit word count N, big-endian (HDR_HI then HDR_LO). This is followed by N words of BPW = DATA_WIDTH/8 bytes each, most significant byte first.
- IDLE/DONE/ERROR: on start_load, clear load_complete, load_error, error_code, words_loaded and mem_addr, then go to HDR_HI. In DONE/ERROR without start_load, hold all flags. start_load is ignored in every other state.
- HDR_HI: on transfer, latch count[15:8] and go to HDR_LO.
- HDR_LO: on transfer, latch count[7:0], then branch on the full 16-bit count:
  - count > DEPTH: set error_code=01 and load_error=1, go to ERROR. The payload is not consumed.
  - count == 0: go to DONE, or to CHECK when the checksum feature is compiled in.
  - otherwise: go to DATA with the byte index cleared.
- DATA: shift each transferred byte into the word register. On the transfer of byte BPW-1, register mem_write_data, assert mem_write=1 and go to WRITE.
- WRITE: exactly one cycle, with in_ready=0 and mem_addr stable during the strobe. Next edge:
  - deassert mem_write and increment words_loaded;
  - if words_loaded+1 == count, go to DONE (or CHECK), keeping mem_addr at the last address;
  - otherwise increment mem_addr and return to DATA.
- Write-address range: mem_addr never wraps within a load. The count ≤ DEPTH check guarantees that addresses stay in range.
- DONE: load_complete=1 from the cycle after the final WRITE, or after CHECK.
- Throughput: minimum BPW+1 cycles per word when in_valid is held high.
- Stall: in_valid low in any receiving state holds the state and all registers; there is no timeout.
- Reset during a load: asynchronously returns to IDLE with all outputs 0. Partial memory contents are left as written.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) accumulates every payload byte; header bytes are excluded.
  - After the last word (or after HDR_LO when N=0), state CHECK accepts one byte.
  - If that byte equals (~sum + 1) mod 256, go to DONE. Otherwise set error_code=10 and load_error=1, and go to ERROR.
  - Data already written stays in memory.
- Undefined: the CHECK state, the sum logic and error code 10 are absent. The final WRITE, or N=0, goes directly to DONE.

Test Plan:
- DATA_WIDTH=16, checksum off; stream 00 03 12 34 AB CD 00 01 with in_valid held high -> mem[0]=1234, mem[1]=ABCD, mem[2]=0001. Three single-cycle mem_write pulses spaced 3 cycles apart; words_loaded=3; load_complete=1; in_ready=0 during each WRITE.
- Header 00 21 with ADDR_WIDTH=5 (DEPTH=32) -> no mem_write, load_error=1, error_code=01. Header 00 20 followed by 32 words -> last write at mem_addr=31, load_complete=1.
- Header 00 00 -> load_complete=1 with no writes (checksum off). With the checksum on, a CHECK byte 00 passes.
- With LOADER_CHECKSUM_EN, stream 00 01 01 02 then FD -> load_complete=1. The same stream ending in FE -> error_code=10, load_error=1, and mem[0]=0102 is still written.
- Random in_valid gaps plus start_load pulses asserted mid-load -> data identical to the first scenario, and start_load ignored while busy=1.
- reset asserted in DATA after 3 bytes -> outputs 0 immediately, state IDLE. A new start_load followed by a full stream loads correctly, and start_load from DONE clears load_complete.
